// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage multiply/divide sequencer.
// Operation codes, FSM state encoding and the default datapath width.
package muldiv_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // True for every opcode that reads or writes HI/LO
  function automatic logic isMdOp(input md_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc, q} register pair: shift-add multiply
// (mode=0) or restoring-divide shift/subtract (mode=1). Purely combinational.
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              mode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] accNext,
  output logic [DATA_W-1:0] qNext
);

  logic [DATA_W:0] addSum;
  logic [DATA_W:0] remShift;
  logic            remGe;

  // Select between the multiply and divide iteration
  always_comb begin
    addSum   = {1'b0, acc} + (q[0] ? {1'b0, operand} : {(DATA_W+1){1'b0}});
    remShift = {acc, q[DATA_W-1]};
    remGe    = (remShift >= {1'b0, operand});
    if (mode) begin
      // Restoring step: keep the shifted remainder when the subtract would borrow
      if (remGe) begin
        accNext = DATA_W'(remShift - {1'b0, operand});
        qNext   = {q[DATA_W-2:0], 1'b1};
      end else begin
        accNext = remShift[DATA_W-1:0];
        qNext   = {q[DATA_W-2:0], 1'b0};
      end
    end else begin
      accNext = addSum[DATA_W:1];
      qNext   = {addSum[0], q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: accepts muldiv-class ops, iterates the
// shared step datapath, applies sign fix-up and owns the HI/LO registers.
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid_i,
  input  md_op_e            op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_W-1:0] ZERO     = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONES     = {DATA_W{1'b1}};

  md_state_e         stateR, stateNext;
  logic [CNT_W-1:0]  cntR;
  logic [DATA_W-1:0] accR, qR, operandR, hiR, loR;
  logic              negResR, negRemR, isDivR;

  logic [DATA_W-1:0] accStep, qStep, rsMag, rtMag, quot, rem;
  logic [PROD_W-1:0] product;
  logic              accept, isSigned, rsNeg, rtNeg, divZero, isMulOp, isDivOp;

  function automatic logic [DATA_W-1:0] negIf(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1'b1)) : v;
  endfunction

  // Handshake with EX, operand magnitudes and sign fix-up of the finished result
  always_comb begin
    busy_o   = (stateR != ST_IDLE);
    stall_o  = op_valid_i & busy_o & isMdOp(op_i);
    accept   = op_valid_i & ~stall_o & ~hold_i & ~flush_i & (stateR == ST_IDLE);
    isMulOp  = (op_i == OP_MULT) || (op_i == OP_MULTU);
    isDivOp  = (op_i == OP_DIV) || (op_i == OP_DIVU);
    isSigned = (op_i == OP_MULT) || (op_i == OP_DIV);
    rsNeg    = isSigned & rs_i[DATA_W-1];
    rtNeg    = isSigned & rt_i[DATA_W-1];
    rsMag    = negIf(rs_i, rsNeg);
    rtMag    = negIf(rt_i, rtNeg);
    divZero  = (rt_i == ZERO);
    product  = negResR ? (~{accR, qR} + PROD_W'(1'b1)) : {accR, qR};
    quot     = negIf(qR, negResR);
    rem      = negIf(accR, negRemR);
    result_o = (op_i == OP_MFHI) ? hiR : loR;
    hi_o     = hiR;
    lo_o     = loR;
  end

  muldiv_step #(.DATA_W(DATA_W)) uStep (
    .mode    (stateR == ST_DIV),
    .acc     (accR),
    .q       (qR),
    .operand (operandR),
    .accNext (accStep),
    .qNext   (qStep)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= ST_IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // Next-state logic; a flush abandons any iteration in progress
  always_comb begin
    stateNext = stateR;
    if (flush_i) begin
      stateNext = ST_IDLE;
    end else begin
      case (stateR)
        ST_IDLE: begin
          if (accept && isMulOp) begin
            stateNext = ST_MUL;
          end else if (accept && isDivOp && !divZero) begin
            stateNext = ST_DIV;
          end else begin
            stateNext = ST_IDLE;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cntR == CNT_LAST) begin
            stateNext = ST_FIX;
          end else begin
            stateNext = stateR;
          end
        end
        ST_FIX:  stateNext = ST_IDLE;
        default: stateNext = ST_IDLE;
      endcase
    end
  end

  // Operand capture, iteration registers and HI/LO update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntR     <= CNT_ZERO;
      accR     <= ZERO;
      qR       <= ZERO;
      operandR <= ZERO;
      hiR      <= ZERO;
      loR      <= ZERO;
      negResR  <= 1'b0;
      negRemR  <= 1'b0;
      isDivR   <= 1'b0;
    end else begin
      case (stateR)
        ST_IDLE: begin
          cntR <= CNT_ZERO;
          if (accept) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                accR     <= ZERO;
                qR       <= rtMag;
                operandR <= rsMag;
                negResR  <= rsNeg ^ rtNeg;
                negRemR  <= 1'b0;
                isDivR   <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero completes immediately without iterating
                if (divZero) begin
                  hiR <= rs_i;
                  loR <= ONES;
                end else begin
                  accR     <= ZERO;
                  qR       <= rsMag;
                  operandR <= rtMag;
                  negResR  <= rsNeg ^ rtNeg;
                  negRemR  <= rsNeg;
                  isDivR   <= 1'b1;
                end
              end
              OP_MTHI: hiR <= rs_i;
              OP_MTLO: loR <= rs_i;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush_i) begin
            cntR <= CNT_ZERO;
          end else begin
            accR <= accStep;
            qR   <= qStep;
            cntR <= (cntR == CNT_LAST) ? CNT_ZERO : cntR + CNT_W'(1'b1);
          end
        end
        ST_FIX: begin
          cntR <= CNT_ZERO;
          if (!flush_i) begin
            if (isDivR) begin
              loR <= quot;
              hiR <= rem;
            end else begin
              hiR <= product[PROD_W-1:DATA_W];
              loR <= product[DATA_W-1:0];
            end
          end
        end
        default: cntR <= CNT_ZERO;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: stimulus pushes expected starts, busy
// lengths, HI/LO results and read data; a negedge monitor pops and compares.
module tb_ex_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  md_op_e      op = OP_NONE;
  logic [31:0] rs = 32'd0, rt = 32'd0;
  logic        hold = 1'b0, flush = 1'b0;
  logic        stall_o, busy_o;
  logic [31:0] result_o, hi_o, lo_o;

  typedef struct packed { logic [31:0] hi; logic [31:0] lo; } hl_t;
  typedef struct packed { logic [31:0] val; logic [31:0] stalls; } rd_t;

  hl_t hlQ[$];
  rd_t rdQ[$];
  int  startQ[$];
  int  lenQ[$];

  int checks = 0, failures = 0, cyc = 0;
  int runLen = 0, stallCnt = 0;
  logic prevBusy = 1'b0, pendWr = 1'b0;

  ex_muldiv_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid_i(op_valid), .op_i(op), .rs_i(rs), .rt_i(rt),
    .hold_i(hold), .flush_i(flush), .stall_o(stall_o), .busy_o(busy_o),
    .result_o(result_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic noEntry(input string name);
    checks++;
    failures++;
    $display("FAIL %s: unexpected event, nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares each observable DUT event against the head of its queue
  always @(negedge clk) begin
    hl_t e; rd_t r;
    if (!rst_n) begin
      cmp("rst_busy", 32'(busy_o), 32'd0);
      cmp("rst_stall", 32'(stall_o), 32'd0);
      cmp("rst_hi", hi_o, 32'd0);
      cmp("rst_lo", lo_o, 32'd0);
    end
    if (pendWr) begin
      pendWr = 1'b0;
      if (hlQ.size() == 0) noEntry("single_cycle_write");
      else begin e = hlQ.pop_front(); cmp("wr_hi", hi_o, e.hi); cmp("wr_lo", lo_o, e.lo); end
    end
    if (prevBusy && !busy_o) begin
      if (hlQ.size() == 0) noEntry("busy_end_hilo");
      else begin e = hlQ.pop_front(); cmp("end_hi", hi_o, e.hi); cmp("end_lo", lo_o, e.lo); end
      if (lenQ.size() == 0) noEntry("busy_len");
      else cmp("busy_len", runLen, lenQ.pop_front());
      runLen = 0;
    end
    if (busy_o && !prevBusy) begin
      if (startQ.size() == 0) noEntry("busy_start");
      else cmp("start_cycle", cyc, startQ.pop_front());
    end
    if (busy_o) runLen++;
    if (rst_n && op_valid && stall_o) stallCnt++;
    if (rst_n && op_valid && !stall_o && !hold && !flush) begin
      if (op == OP_MFHI || op == OP_MFLO) begin
        if (rdQ.size() == 0) noEntry("read");
        else begin r = rdQ.pop_front(); cmp("read_data", result_o, r.val); cmp("read_stalls", stallCnt, r.stalls); end
      end else if (op == OP_MTHI || op == OP_MTLO ||
                   ((op == OP_DIV || op == OP_DIVU) && rt == 32'd0)) begin
        pendWr = 1'b1;
      end
      stallCnt = 0;
    end
    prevBusy = busy_o;
  end

  // All stimulus tasks start and end at posedge+1
  task automatic issue(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
  endtask

  task automatic iterOp(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eHi, input logic [31:0] eLo, input int len);
    startQ.push_back(cyc + 1);
    lenQ.push_back(len);
    hlQ.push_back('{hi: eHi, lo: eLo});
    issue(o, a, b);
  endtask

  task automatic readReg(input md_op_e o, input logic [31:0] exp, input int stalls);
    bit done = 1'b0;
    rdQ.push_back('{val: exp, stalls: 32'(stalls)});
    op_valid = 1'b1; op = o;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!stall_o) done = 1'b1;
    end
    if (!done) begin checks++; failures++; $display("FAIL read_timeout: got stalled expected release"); end
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
  endtask

  task automatic waitIdle();
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!busy_o) done = 1'b1;
    end
    if (!done) begin checks++; failures++; $display("FAIL idle_timeout: got busy expected idle"); end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // MULT -2*3, then MFLO stalls for the whole run
    iterOp(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
    readReg(OP_MFLO, 32'hFFFF_FFFA, 33);

    // Divides
    iterOp(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
    waitIdle();
    iterOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    waitIdle();
    iterOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    waitIdle();
    readReg(OP_MFHI, 32'h0000_0000, 0);
    readReg(OP_MFLO, 32'h8000_0000, 0);

    // Divide by zero: single-cycle write, no busy
    hlQ.push_back('{hi: 32'h1234_5678, lo: 32'hFFFF_FFFF});
    issue(OP_DIV, 32'h1234_5678, 32'd0);
    @(posedge clk); #1;

    // Flush on busy cycle 10, then on the FIX cycle: HI/LO untouched
    iterOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 10);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    waitIdle();
    iterOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 33);
    repeat (32) begin @(posedge clk); #1; end
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    waitIdle();

    // Flush coincident with a would-be accept: no start
    flush = 1'b1;
    issue(OP_MULT, 32'd5, 32'd5);
    flush = 1'b0;
    @(posedge clk); #1;

    // MULT held for 5 cycles then released: exactly one start
    op_valid = 1'b1; op = OP_MULT; rs = 32'd7; rt = 32'hFFFF_FFFD; hold = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    hold = 1'b0;
    startQ.push_back(cyc + 1);
    lenQ.push_back(33);
    hlQ.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB});
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NONE;
    waitIdle();

    // MTHI/MTLO followed immediately by reads
    hlQ.push_back('{hi: 32'hA5A5_A5A5, lo: 32'hFFFF_FFEB});
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
    readReg(OP_MFHI, 32'hA5A5_A5A5, 0);
    hlQ.push_back('{hi: 32'hA5A5_A5A5, lo: 32'h1357_9BDF});
    issue(OP_MTLO, 32'h1357_9BDF, 32'd0);
    readReg(OP_MFLO, 32'h1357_9BDF, 0);

    // Reset mid-DIV after 10 busy cycles
    iterOp(OP_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 10);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Normal operation resumes after reset
    iterOp(OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33);
    waitIdle();
    readReg(OP_MFLO, 32'd42, 0);

    repeat (3) @(posedge clk);
    cmp("hlQ_drained", 32'(hlQ.size()), 32'd0);
    cmp("rdQ_drained", 32'(rdQ.size()), 32'd0);
    cmp("startQ_drained", 32'(startQ.size()), 32'd0);
    cmp("lenQ_drained", 32'(lenQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
